// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM stage of the five-stage MIPS pipeline, between EX and WB. Executes
// big-endian byte/halfword/word loads and stores over a req/ack data-memory
// port, checks alignment, stalls EX until memory acknowledges and presents
// registered write-back data to WB.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   valid_in, mem_op    EX instruction valid and memory opcode (0 NONE, 1 LB,
//                       2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, else NONE)
//   addr_in             effective address
//   store_data_in       rt value for stores
//   alu_result_in       result forwarded for non-memory ops
//   reg_write_en_in     write-back enable from EX
//   reg_addr_in         destination register
//   stall_req           hold EX/MEM inputs while high
//   mem_req, mem_we     memory request (held until ack) and write strobe
//   mem_addr, mem_be    word-aligned address and byte enables (bit 3 = 31:24)
//   mem_wdata           lane-replicated store data
//   mem_rdata, mem_ack  read data and single-cycle completion
//   valid_out, data_out, reg_write_en_out, reg_addr_out   registered WB outputs
//   addr_err            one-cycle pulse on misaligned access or ack timeout
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [3:0]            mem_op,
   input  logic [ADDR_W-1:0]     addr_in,
   input  logic [31:0]           store_data_in,
   input  logic [31:0]           alu_result_in,
   input  logic                  reg_write_en_in,
   input  logic [REG_ADDR_W-1:0] reg_addr_in,
   output logic                  stall_req,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ack,
   output logic                  valid_out,
   output logic [31:0]           data_out,
   output logic                  reg_write_en_out,
   output logic [REG_ADDR_W-1:0] reg_addr_out,
   output logic                  addr_err
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   // Value of the wait counter during the last WAIT cycle before giving up.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
   typedef enum logic {S_IDLE, S_WAIT} state_e;

   state_e     state;
   logic [7:0] wait_cnt;
   logic [3:0] op_q;
   logic [1:0] off_q;
   logic       wb_en_q;

   size_e      size;
   logic       is_store;
   logic       misaligned;
   logic       accept;
   logic       timeout_hit;
   logic [3:0] be_new;
   logic [31:0] wdata_new;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_data;

   // Decode of the incoming EX op and the bus image it will produce.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      size      = SZ_NONE;
      is_store  = 1'b0;
      be_new    = 4'b0000;
      wdata_new = 32'h0;
      case (mem_op)
         OP_LB, OP_LBU: size = SZ_BYTE;
         OP_LH, OP_LHU: size = SZ_HALF;
         OP_LW:         size = SZ_WORD;
         OP_SB:         begin size = SZ_BYTE; is_store = 1'b1; end
         OP_SH:         begin size = SZ_HALF; is_store = 1'b1; end
         OP_SW:         begin size = SZ_WORD; is_store = 1'b1; end
         default:       size = SZ_NONE;
      endcase
      case (size)
         SZ_BYTE: begin
            be_new    = 4'b1000 >> addr_in[1:0];
            wdata_new = {4{store_data_in[7:0]}};
         end
         SZ_HALF: begin
            be_new    = addr_in[1] ? 4'b0011 : 4'b1100;
            wdata_new = {2{store_data_in[15:0]}};
         end
         SZ_WORD: begin
            be_new    = 4'b1111;
            wdata_new = store_data_in;
         end
         default: be_new = 4'b0000;
      endcase
      if (!is_store) wdata_new = 32'h0;
   end

   assign misaligned  = ((size == SZ_HALF) && addr_in[0]) ||
                        ((size == SZ_WORD) && (addr_in[1:0] != 2'b00));
   assign accept      = (state == S_IDLE) && valid_in && (size != SZ_NONE) && !misaligned;
   assign timeout_hit = (state == S_WAIT) && !mem_ack && (wait_cnt == WAIT_LAST);

   // The timeout cycle also releases the stall: the failed instruction retires
   // with addr_err, so EX must advance instead of re-presenting it.
   assign stall_req = !rst && (accept || ((state == S_WAIT) && !mem_ack && !timeout_hit));

   // Big-endian lane select: byte offset 0 lives in bits 31:24.
   always_comb begin
      case (off_q)
         2'd0:    lane_b = mem_rdata[31:24];
         2'd1:    lane_b = mem_rdata[23:16];
         2'd2:    lane_b = mem_rdata[15:8];
         default: lane_b = mem_rdata[7:0];
      endcase
      lane_h = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
      case (op_q)
         OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  load_data = {24'h0, lane_b};
         OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  load_data = {16'h0, lane_h};
         OP_LW:   load_data = mem_rdata;
         default: load_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples values from before this edge, independent of statement order.
      if (rst) begin
         state            <= S_IDLE;
         wait_cnt         <= 8'h0;
         op_q             <= 4'h0;
         off_q            <= 2'b00;
         wb_en_q          <= 1'b0;
         mem_req          <= 1'b0;
         mem_we           <= 1'b0;
         mem_addr         <= '0;
         mem_be           <= 4'b0000;
         mem_wdata        <= 32'h0;
         valid_out        <= 1'b0;
         data_out         <= 32'h0;
         reg_write_en_out <= 1'b0;
         reg_addr_out     <= '0;
         addr_err         <= 1'b0;
      end else begin
         // WB outputs are single-cycle pulses unless a branch below sets them.
         valid_out        <= 1'b0;
         reg_write_en_out <= 1'b0;
         addr_err         <= 1'b0;
         case (state)
            S_IDLE: begin
               reg_addr_out <= reg_addr_in;
               if (valid_in && (size != SZ_NONE)) begin
                  if (misaligned) begin
                     valid_out <= 1'b1;
                     addr_err  <= 1'b1;
                     data_out  <= 32'h0;
                  end else begin
                     state     <= S_WAIT;
                     wait_cnt  <= 8'h0;
                     op_q      <= mem_op;
                     off_q     <= addr_in[1:0];
                     wb_en_q   <= reg_write_en_in;
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
                     mem_be    <= be_new;
                     mem_wdata <= wdata_new;
                  end
               end else begin
                  valid_out        <= valid_in;
                  data_out         <= alu_result_in;
                  reg_write_en_out <= reg_write_en_in & valid_in;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  state            <= S_IDLE;
                  mem_req          <= 1'b0;
                  valid_out        <= 1'b1;
                  data_out         <= mem_we ? 32'h0 : load_data;
                  reg_write_en_out <= !mem_we && wb_en_q;
               end else if (timeout_hit) begin
                  state     <= S_IDLE;
                  mem_req   <= 1'b0;
                  valid_out <= 1'b1;
                  addr_err  <= 1'b1;
                  data_out  <= 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Self-checking bench for mem_stage_lsu: a table of directed memory vectors,
// hand-written multi-cycle sequences (latency, misalignment, timeout, reset
// during WAIT) and randomized traffic checked against a transaction-level
// model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

   localparam int TIMEOUT = 255;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [3:0]  mem_op;
   logic [31:0] addr_in;
   logic [31:0] store_data_in;
   logic [31:0] alu_result_in;
   logic        reg_write_en_in;
   logic [4:0]  reg_addr_in;
   logic        stall_req;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        valid_out;
   logic [31:0] data_out;
   logic        reg_write_en_out;
   logic [4:0]  reg_addr_out;
   logic        addr_err;

   mem_stage_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .mem_op(mem_op),
      .addr_in(addr_in), .store_data_in(store_data_in),
      .alu_result_in(alu_result_in), .reg_write_en_in(reg_write_en_in),
      .reg_addr_in(reg_addr_in), .stall_req(stall_req), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .valid_out(valid_out), .data_out(data_out),
      .reg_write_en_out(reg_write_en_out), .reg_addr_out(reg_addr_out),
      .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected WB result of the most recent instruction, due one cycle later.
   logic        exp_v, exp_we, exp_err, chk_data, chk_rd;
   logic [31:0] exp_data;
   logic [4:0]  exp_rd;

   // Bus image seen in the first WAIT cycle of the last memory op.
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_be;
   logic        obs_we;
   int          obs_req_cycles;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic int op_size(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   // Bytes off .. off+size-1 are touched; byte i sits on be bit 3-i.
   function automatic logic [3:0] model_be(input int size, input int off);
      logic [3:0] be;
      be = 4'b0000;
      for (int i = 0; i < 4; i++)
         if (i >= off && i < off + size) be[3-i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input int size, input logic [31:0] d);
      if (size == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (size == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] w, input int off);
      logic [31:0] r;
      r = 32'h0;
      case (op)
         OP_LB, OP_LBU: begin
            r = (w >> (8 * (3 - off))) & 32'hFF;
            if (op == OP_LB && r[7]) r = r | 32'hFFFF_FF00;
         end
         OP_LH, OP_LHU: begin
            r = (w >> (8 * (2 - off))) & 32'hFFFF;
            if (op == OP_LH && r[15]) r = r | 32'hFFFF_0000;
         end
         OP_LW:   r = w;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic check_result();
      check("valid_out", valid_out, exp_v);
      check("addr_err", addr_err, exp_err);
      check("reg_write_en_out", reg_write_en_out, exp_we);
      if (exp_v && chk_data) check("data_out", data_out, exp_data);
      if (exp_v && chk_rd)   check("reg_addr_out", reg_addr_out, exp_rd);
   endtask

   // Present one instruction as EX would (held while stalled), act as memory
   // acking after `lat` no-ack WAIT cycles, and record the expected WB result.
   // Returns at #1 after the edge that registers that result.
   task automatic issue(input logic v, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] alu, input logic we,
                        input logic [4:0] rd, input logic [31:0] rdata, input int lat,
                        input logic idle_ack, output int stalls);
      int   size, off;
      logic accepted, timed_out;
      size = op_size(op);
      off  = int'(addr[1:0]);
      valid_in = v; mem_op = op; addr_in = addr; store_data_in = sd;
      alu_result_in = alu; reg_write_en_in = we; reg_addr_in = rd;
      mem_ack = idle_ack; mem_rdata = $urandom;
      obs_req_cycles = 0;
      @(negedge clk);
      check_result();
      check("idle mem_req", mem_req, 1'b0);
      accepted = v && (size != 0) && ((off % size) == 0);
      check("accept stall_req", stall_req, accepted);
      stalls = int'(stall_req);
      timed_out = 1'b0;
      if (accepted) begin
         timed_out = 1'b1;
         for (int w = 0; w < TIMEOUT; w++) begin
            @(posedge clk); #1;
            mem_ack   = (w == lat);
            mem_rdata = (w == lat) ? rdata : $urandom;
            @(negedge clk);
            if (w == 0) begin
               check("wait valid_out", valid_out, 1'b0);
               check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
               check("mem_be", mem_be, model_be(size, off));
               check("mem_we", mem_we, op >= OP_SB);
               if (op >= OP_SB) check("mem_wdata", mem_wdata, model_wdata(size, sd));
               obs_addr = mem_addr; obs_be = mem_be; obs_we = mem_we; obs_wdata = mem_wdata;
            end
            check("wait mem_req", mem_req, 1'b1);
            check("wait stall_req", stall_req, !(mem_ack || (w == TIMEOUT - 1)));
            stalls += int'(stall_req);
            obs_req_cycles += int'(mem_req);
            if (w == lat) begin
               timed_out = 1'b0;
               break;
            end
         end
      end
      if (accepted && !timed_out) begin
         exp_v = 1'b1; exp_err = 1'b0; exp_we = (op <= OP_LW) && we;
         exp_data = model_load(op, rdata, off); chk_data = (op <= OP_LW);
         exp_rd = rd; chk_rd = 1'b1;
      end else if (accepted || (v && size != 0)) begin
         // timeout or misaligned access
         exp_v = 1'b1; exp_err = 1'b1; exp_we = 1'b0;
         exp_data = 32'h0; chk_data = 1'b0; exp_rd = rd; chk_rd = 1'b0;
      end else begin
         exp_v = v; exp_err = 1'b0; exp_we = v && we;
         exp_data = alu; chk_data = 1'b1; exp_rd = rd; chk_rd = 1'b1;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; valid_in = 1'b0; mem_op = OP_NONE;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] data;
      logic        we_out;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int st;
      vecs[0]  = '{OP_LB,  32'h100, 32'h0,         32'h7FBB_CC80, 4'b1000, 32'h0,         32'h0000_007F, 1'b1};
      vecs[1]  = '{OP_LB,  32'h102, 32'h0,         32'hAABB_CC80, 4'b0010, 32'h0,         32'hFFFF_FFCC, 1'b1};
      vecs[2]  = '{OP_LBU, 32'h101, 32'h0,         32'hAABB_CC80, 4'b0100, 32'h0,         32'h0000_00BB, 1'b1};
      vecs[3]  = '{OP_LH,  32'h102, 32'h0,         32'h1234_8001, 4'b0011, 32'h0,         32'hFFFF_8001, 1'b1};
      vecs[4]  = '{OP_LHU, 32'h100, 32'h0,         32'h8001_1234, 4'b1100, 32'h0,         32'h0000_8001, 1'b1};
      vecs[5]  = '{OP_LH,  32'h100, 32'h0,         32'h7FFF_8000, 4'b1100, 32'h0,         32'h0000_7FFF, 1'b1};
      vecs[6]  = '{OP_LW,  32'h104, 32'h0,         32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b1};
      vecs[7]  = '{OP_SB,  32'h101, 32'h1234_56A5, 32'h0,         4'b0100, 32'hA5A5_A5A5, 32'h0,         1'b0};
      vecs[8]  = '{OP_SB,  32'h103, 32'h0000_0011, 32'h0,         4'b0001, 32'h1111_1111, 32'h0,         1'b0};
      vecs[9]  = '{OP_SW,  32'h300, 32'h0123_4567, 32'h0,         4'b1111, 32'h0123_4567, 32'h0,         1'b0};
      vecs[10] = '{OP_SH,  32'h200, 32'hDEAD_BEEF, 32'h0,         4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0};

      // Reset with a valid aligned load presented: nothing may escape.
      rst = 1'b1; valid_in = 1'b1; mem_op = OP_LW; addr_in = 32'h0;
      store_data_in = 32'h0; alu_result_in = 32'hFFFF_FFFF; reg_write_en_in = 1'b1;
      reg_addr_in = 5'd31; mem_rdata = 32'h0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst stall_req", stall_req, 1'b0);
      check("rst mem_req", mem_req, 1'b0);
      check("rst valid_out", valid_out, 1'b0);
      check("rst data_out", data_out, 32'h0);
      check("rst reg_addr_out", reg_addr_out, 5'd0);
      check("rst addr_err", addr_err, 1'b0);
      check("rst reg_write_en_out", reg_write_en_out, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; valid_in = 1'b0; mem_op = OP_NONE;
      exp_v = 1'b0; exp_we = 1'b0; exp_err = 1'b0; chk_data = 1'b0; chk_rd = 1'b0;
      exp_data = 32'h0; exp_rd = 5'd0;

      // ALU passthrough.
      issue(1'b1, OP_NONE, 32'h0, 32'h0, 32'h1234_5678, 1'b1, 5'd5, 32'h0, 0, 1'b0, st);
      check("alu valid_out", valid_out, 1'b1);
      check("alu data_out", data_out, 32'h1234_5678);
      check("alu reg_addr_out", reg_addr_out, 5'd5);
      check("alu we_out", reg_write_en_out, 1'b1);
      check("alu stall_req", stall_req, 1'b0);

      // LB with three no-ack WAIT cycles, then LBU back to back.
      issue(1'b1, OP_LB, 32'h103, 32'h0, 32'h0, 1'b1, 5'd9, 32'hAABB_CC80, 3, 1'b0, st);
      check("lb stall cycles", st, 4);
      check("lb mem_addr", obs_addr, 32'h100);
      check("lb mem_be", obs_be, 4'b0001);
      check("lb data_out", data_out, 32'hFFFF_FF80);
      issue(1'b1, OP_LBU, 32'h103, 32'h0, 32'h0, 1'b1, 5'd9, 32'hAABB_CC80, 0, 1'b0, st);
      check("lbu data_out", data_out, 32'h0000_0080);

      // SH at offset 2.
      issue(1'b1, OP_SH, 32'h202, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd4, 32'h0, 1, 1'b0, st);
      check("sh mem_we", obs_we, 1'b1);
      check("sh mem_be", obs_be, 4'b0011);
      check("sh mem_wdata", obs_wdata, 32'hBEEF_BEEF);
      check("sh valid_out", valid_out, 1'b1);
      check("sh we_out", reg_write_en_out, 1'b0);

      // Misaligned LW: no request, error pulse next cycle.
      issue(1'b1, OP_LW, 32'h102, 32'h0, 32'h0, 1'b1, 5'd6, 32'h0, 0, 1'b0, st);
      check("mis mem_req", mem_req, 1'b0);
      check("mis addr_err", addr_err, 1'b1);
      check("mis valid_out", valid_out, 1'b1);
      check("mis we_out", reg_write_en_out, 1'b0);

      // Directed table, latency varied per vector.
      foreach (vecs[i]) begin
         issue(1'b1, vecs[i].op, vecs[i].addr, vecs[i].sd, 32'h0, 1'b1, 5'd12,
               vecs[i].rdata, i % 3, 1'b0, st);
         check($sformatf("vec%0d mem_addr", i), obs_addr, vecs[i].addr & 32'hFFFF_FFFC);
         check($sformatf("vec%0d mem_be", i), obs_be, vecs[i].be);
         if (vecs[i].op >= OP_SB) check($sformatf("vec%0d mem_wdata", i), obs_wdata, vecs[i].wdata);
         check($sformatf("vec%0d valid_out", i), valid_out, 1'b1);
         check($sformatf("vec%0d we_out", i), reg_write_en_out, vecs[i].we_out);
         if (vecs[i].op <= OP_LW) check($sformatf("vec%0d data_out", i), data_out, vecs[i].data);
      end

      // Timeout, then a normal LW immediately after.
      issue(1'b1, OP_LW, 32'h500, 32'h0, 32'h0, 1'b1, 5'd7, 32'h0, TIMEOUT + 10, 1'b0, st);
      check("to mem_req cycles", obs_req_cycles, TIMEOUT);
      check("to mem_req dropped", mem_req, 1'b0);
      check("to addr_err", addr_err, 1'b1);
      check("to valid_out", valid_out, 1'b1);
      check("to we_out", reg_write_en_out, 1'b0);
      issue(1'b1, OP_LW, 32'h504, 32'h0, 32'h0, 1'b1, 5'd7, 32'h1357_9BDF, 0, 1'b0, st);
      check("post-to data_out", data_out, 32'h1357_9BDF);
      check("post-to addr_err", addr_err, 1'b0);

      // Reset in the second WAIT cycle; a late ack must be ignored.
      valid_in = 1'b1; mem_op = OP_LW; addr_in = 32'h400; reg_write_en_in = 1'b1;
      reg_addr_in = 5'd3; mem_ack = 1'b0;
      @(negedge clk);
      check_result();
      check("rw accept stall_req", stall_req, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rw wait1 mem_req", mem_req, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rw wait2 mem_req", mem_req, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0; valid_in = 1'b0; mem_op = OP_NONE; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("rw mem_req", mem_req, 1'b0);
      check("rw stall_req", stall_req, 1'b0);
      check("rw valid_out", valid_out, 1'b0);
      check("rw data_out", data_out, 32'h0);
      check("rw reg_addr_out", reg_addr_out, 5'd0);
      check("rw addr_err", addr_err, 1'b0);
      check("rw we_out", reg_write_en_out, 1'b0);
      check("rw mem_we", mem_we, 1'b0);
      check("rw mem_be", mem_be, 4'b0000);
      check("rw mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      exp_v = 1'b0; exp_we = 1'b0; exp_err = 1'b0; chk_data = 1'b0; chk_rd = 1'b0;
      issue(1'b1, OP_LW, 32'h404, 32'h0, 32'h0, 1'b1, 5'd3, 32'h600D_F00D, 1, 1'b0, st);
      check("rw new data_out", data_out, 32'h600D_F00D);
      check("rw new reg_addr_out", reg_addr_out, 5'd3);

      // Randomized traffic, including illegal opcodes and stray idle acks.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
         issue($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), a, $urandom, $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 5), 1'($urandom_range(0, 1)), st);
      end
      issue(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1'b0, st);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
